mod_add_arbiter: RTL
====================

# mod_add_arbiter

Sequential front end that shares one combinational `ParallelPrefixModularAdder` instance between two requesters. It also owns the adder's modulus-complement register K, where modulus M = 2^N − K. Each accepted request computes (A + B) mod M through a registered datapath, and the result is returned on a single response channel tagged with the requester ID. Grants rotate round-robin, so neither requester can starve the other.

## Interface
Parameters:
- `N`, 8, operand/result width
- `K_RESET`, 1, reset value of K register (M = 2^N − 1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `req_valid`  in  2  per-requester request strobe (bit i = requester i)
- `req_ready`  out  2  per-requester accept; at most one bit set
- `req_a0`, `req_b0`  in  N each  operands, requester 0
- `req_a1`, `req_b1`  in  N each  operands, requester 1
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  consumer accepts result
- `resp_data`  out  N  (A + B) mod M
- `resp_id`  out  1  requester that issued this result
- `resp_err`  out  1  operand out of range (see Configuration)
- `cfg_we`  in  1  load new K
- `cfg_k`  in  N  new K value
- `cfg_busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE → CALC → RESP → IDLE.
- IDLE:
  - `req_ready` is driven to the granted requester only.
  - Grant goes to the sole valid requester. If both are valid, grant goes to the one not served last (`rr_last` flop).
  - On handshake: latch the operands and the ID, set `rr_last`, then go to CALC.
- CALC: the adder sees the latched operands and the K register. The result is captured into `resp_data` at the end of the cycle, then go to RESP.
- RESP:
  - `resp_valid` = 1. `resp_data`, `resp_id` and `resp_err` stay stable until `resp_ready`.
  - On `resp_valid & resp_ready`, go to IDLE.
- `cfg_we` is honoured only in IDLE, and takes priority there: `req_ready` = 0 that cycle and K ← `cfg_k`. `cfg_we` outside IDLE is ignored with no effect.
- K is never changed while an operation is in flight. The result always uses the K value latched before the accept.
- Arithmetic: operands are valid in [0, M−1]. Behaviour for out-of-range operands is set only by the Configuration macro.
- `req_valid` deasserted before a handshake: no grant, and `rr_last` is unchanged.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready` = 0
  - `resp_valid` = 0
  - `resp_data` = 0
  - `resp_id` = 0
  - `resp_err` = 0
  - `cfg_busy` = 0
  - K = `K_RESET`
  - `rr_last` = 1, so requester 0 wins the first tie.
- Latency: request handshake at cycle t means `resp_valid` = 1 at t+2.
- Throughput: one operation per 3 cycles when `resp_ready` is held high. The next accept is possible in the cycle after the response handshake.
- `req_ready` is a combinational function of state, `req_valid`, `rr_last` and `cfg_we`. It is never asserted outside IDLE.
- Reset mid-operation returns to IDLE next cycle. Any pending response is discarded, and K reverts to `K_RESET`.
- `resp_ready` held low stalls in RESP indefinitely. Requests are then not accepted.

## Configuration
- Macro: `MODADD_RANGE_CHECK_EN`.
- Defined:
  - In CALC, compare each operand against M using N+1-bit arithmetic.
  - If either operand ≥ M: `resp_err` = 1 and `resp_data` = 0.
  - Otherwise `resp_err` = 0.
- Undefined:
  - `resp_err` is tied 0 and no comparator is built.
  - Out-of-range operands give an unspecified `resp_data`.

## Structure
- Shared package `mod_add_pkg`:
  - FSM state enum (IDLE, CALC, RESP)
  - requester-count constant (2)
  - ID width constant (1)
- One sub-module: `ParallelPrefixModularAdder #(N)`, instantiated once and fed from the operand registers and the K register.
- All other logic is flat in `mod_add_arbiter`.

## Test plan
All scenarios use N=7, K_RESET=5 (M=123), unless stated otherwise.
1. **Basic accept.** Requester 0 sends a=53, b=60 with `resp_ready`=1. Expect `resp_data`=113, `resp_id`=0, `resp_valid` exactly 2 cycles after the handshake.
2. **Wrap-around.** Requester 1 sends a=100, b=50. Expect `resp_data`=27, `resp_id`=1. Also a=122, b=1 → 0.
3. **Round-robin.** Both requesters hold valid for 4 operations. Expect grants in order 0, 1, 0, 1. Expect `req_ready` never asserted while `cfg_busy`=1.
4. **Backpressure and reconfiguration.**
   - Hold `resp_ready`=0 for 5 cycles: `resp_data` stays stable, no new accept, `cfg_we` with `cfg_k`=1 in RESP is ignored.
   - After release, `cfg_we` with `cfg_k`=1 in IDLE: 100+50 → 23 (M=127).
5. **Reset mid-operation.** Assert `rst` in CALC. Next cycle: IDLE, `resp_valid`=0, K=5. The following request 53+60 returns 113.
6. **Range check** (`MODADD_RANGE_CHECK_EN` defined). a=124, b=1 gives `resp_err`=1, `resp_data`=0. a=122, b=0 gives `resp_err`=0, `resp_data`=122.

Source files
------------

// File: rtl/mod_add_pkg.sv
// Shared definitions for the two-requester modular-add arbiter.
package mod_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

endpackage

// File: rtl/ParallelPrefixModularAdder.sv
// Combinational (a + b) mod (2^N - k) built from two Kogge-Stone prefix adders.
module ParallelPrefixModularAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] k,
    output logic [N-1:0] sum
);

    localparam int W = N + 1;

    function automatic logic [W-1:0] ks_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] g, p, h, g_n, p_n, s;
        h = x ^ y;
        g = x & y;
        p = h;
        for (int d = 1; d < W; d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int i = d; i < W; i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        s[0] = h[0];
        for (int i = 1; i < W; i++) begin
            s[i] = h[i] ^ g[i-1];
        end
        return s;
    endfunction

    logic [W-1:0] raw;
    logic [W-1:0] shifted;

    // raw + k reaching 2^N means raw >= M, and its low bits are then raw - M.
    assign raw     = ks_add({1'b0, a}, {1'b0, b});
    assign shifted = ks_add(raw, {1'b0, k});
    assign sum     = shifted[N] ? shifted[N-1:0] : raw[N-1:0];

endmodule

// File: rtl/mod_add_arbiter.sv
// Round-robin front end sharing one modular adder between two requesters.
// Optional operand range check: define MODADD_RANGE_CHECK_EN.
module mod_add_arbiter
    import mod_add_pkg::*;
#(
    parameter int N       = 8,
    parameter int K_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [N-1:0]       req_a0,
    input  logic [N-1:0]       req_b0,
    input  logic [N-1:0]       req_a1,
    input  logic [N-1:0]       req_b1,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [N-1:0]       resp_data,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_err,
    input  logic               cfg_we,
    input  logic [N-1:0]       cfg_k,
    output logic               cfg_busy
);

    state_t          state;
    logic [N-1:0]    a_q, b_q, k_q, sum;
    logic [ID_W-1:0] id_q, gnt_id;
    logic            rr_last;
    logic            accept;
    logic            range_err;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_id    = '0;
        req_ready = '0;
        if (req_valid == 2'b11) begin
            gnt_id = ~rr_last;
        end else begin
            gnt_id = req_valid[1];
        end
        if (state == IDLE && !cfg_we && |req_valid) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign cfg_busy = (state != IDLE);

    ParallelPrefixModularAdder #(.N(N)) u_adder (
        .a   (a_q),
        .b   (b_q),
        .k   (k_q),
        .sum (sum)
    );

`ifdef MODADD_RANGE_CHECK_EN
    logic [N:0] m_ext;
    assign m_ext     = {1'b1, {N{1'b0}}} - {1'b0, k_q};
    assign range_err = ({1'b0, a_q} >= m_ext) || ({1'b0, b_q} >= m_ext);
`else
    assign range_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= N'(K_RESET);
            id_q       <= '0;
            rr_last    <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        k_q <= cfg_k;
                    end else if (accept) begin
                        a_q     <= gnt_id[0] ? req_a1 : req_a0;
                        b_q     <= gnt_id[0] ? req_b1 : req_b0;
                        id_q    <= gnt_id;
                        rr_last <= gnt_id[0];
                        state   <= CALC;
                    end
                end
                CALC: begin
                    resp_data  <= range_err ? '0 : sum;
                    resp_err   <= range_err;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
